// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter between the display scan-out reader
// and a host bus (read/write). Display has priority; after each display read
// a holdoff counter masks the display request to absorb its registered lag.
// Optional macro VRAM_ARB_FAIRNESS_EN: a starvation counter forces a bus grant
// after STARVE_MAX consecutive display grants taken while the bus waited.
module vram_arbiter #(
    parameter int MEM_LAT      = 1,
    parameter int DISP_HOLDOFF = 2,
    parameter int STARVE_MAX   = 4
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        disp_req,
    input  logic [14:0] disp_addr,
    output logic        disp_ready,
    output logic [31:0] disp_data,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [14:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int HW = (DISP_HOLDOFF < 1) ? 1 : $clog2(DISP_HOLDOFF + 1);

    typedef enum logic [1:0] {IDLE, DRD, BRD, BWR} state_t;

    state_t        state;
    logic [1:0]    lat_cnt;
    logic [HW-1:0] holdoff;
    logic          disp_elig;
    logic          bus_go;
    logic          disp_go;

    // Display is eligible only once the post-read holdoff has expired.
    assign disp_elig = disp_req && (holdoff == '0);
    // A bus request still high in its ack cycle is the one just served.
    assign bus_go    = (bus_rd || bus_wr) && !bus_ack;

`ifdef VRAM_ARB_FAIRNESS_EN
    logic [2:0] starve;
    logic       starve_hit;

    assign starve_hit = bus_go && (starve >= 3'(STARVE_MAX));
    assign disp_go    = disp_elig && !starve_hit;

    // Count display grants taken while the bus waits; any bus grant or an
    // idle bus clears the count.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            starve <= '0;
        end else if (!bus_go) begin
            starve <= '0;
        end else if (state == IDLE) begin
            if (disp_go) begin
                if (starve != 3'd7) starve <= starve + 3'd1;
            end else begin
                starve <= '0;
            end
        end
    end
`else
    assign disp_go = disp_elig;
`endif

    // Arbitration FSM; every output is a register set or cleared here.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            holdoff    <= '0;
            disp_ready <= 1'b0;
            bus_ack    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            disp_data  <= '0;
            bus_rdata  <= '0;
        end else begin
            disp_ready <= 1'b0;
            bus_ack    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            if (holdoff != '0) holdoff <= holdoff - 1'b1;
            case (state)
                IDLE: begin
                    lat_cnt <= '0;
                    if (disp_go) begin
                        state    <= DRD;
                        mem_en   <= 1'b1;
                        mem_addr <= disp_addr;
                    end else if (bus_go) begin
                        mem_en    <= 1'b1;
                        mem_addr  <= bus_addr;
                        mem_wdata <= bus_wdata;
                        if (bus_wr) begin
                            mem_we <= 1'b1;
                            state  <= BWR;
                        end else begin
                            state  <= BRD;
                        end
                    end
                end
                DRD: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_cnt == 2'(MEM_LAT)) begin
                        disp_data  <= mem_rdata;
                        disp_ready <= 1'b1;
                        holdoff    <= HW'(DISP_HOLDOFF);
                        state      <= IDLE;
                    end
                end
                BRD: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_cnt == 2'(MEM_LAT)) begin
                        bus_rdata <= mem_rdata;
                        bus_ack   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                BWR: begin
                    bus_ack <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: scoreboard queues filled by the stimulus,
// drained by monitors on disp_ready / bus_ack. A second instance with zero
// display holdoff exercises display-vs-bus starvation.
module tb_vram_arbiter;

    logic        vga_clk = 1'b0;
    logic        reset;
    logic        disp_req, bus_rd, bus_wr;
    logic [14:0] disp_addr, bus_addr;
    logic [31:0] bus_wdata;
    logic        disp_ready, bus_ack, mem_en, mem_we;
    logic [31:0] disp_data, bus_rdata, mem_wdata, mem_rdata;
    logic [14:0] mem_addr;

    logic        disp_req2, bus_rd2;
    logic [14:0] disp_addr2, bus_addr2;
    logic        disp_ready2, bus_ack2, mem_en2, mem_we2;
    logic [31:0] disp_data2, bus_rdata2, mem_wdata2, mem_rdata2;
    logic [14:0] mem_addr2;

    logic [31:0] mem [0:32767];
    logic [31:0] rd1, rd2;

    int checks = 0, failures = 0, cyc = 0;
    int rdy_cyc = 0, ack_cyc = 0;
    int n_rdy2 = 0, n_ack2 = 0, rdy_at_ack = -1;
    logic [31:0] hold_rd;
    logic [31:0] exp_disp[$];
    logic [31:0] exp_bus[$];

    vram_arbiter u_dut (
        .vga_clk(vga_clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_ready(disp_ready), .disp_data(disp_data),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    vram_arbiter #(.MEM_LAT(1), .DISP_HOLDOFF(0), .STARVE_MAX(4)) u_nh (
        .vga_clk(vga_clk), .reset(reset),
        .disp_req(disp_req2), .disp_addr(disp_addr2),
        .disp_ready(disp_ready2), .disp_data(disp_data2),
        .bus_rd(bus_rd2), .bus_wr(1'b0), .bus_addr(bus_addr2),
        .bus_wdata(32'h0), .bus_rdata(bus_rdata2), .bus_ack(bus_ack2),
        .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
    );

    always #5 vga_clk = ~vga_clk;
    always @(posedge vga_clk) cyc++;

    // One-cycle-latency synchronous memory; only the first instance writes.
    always @(posedge vga_clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        rd1 <= mem[mem_addr];
        end
        if (mem_en2) rd2 <= mem[mem_addr2];
    end
    assign mem_rdata  = rd1;
    assign mem_rdata2 = rd2;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge vga_clk) begin
        if (!reset) begin
            if (disp_ready) begin
                rdy_cyc = cyc;
                if (exp_disp.size() == 0) chk("disp_unexpected", 32'd1, 32'd0);
                else chk("disp_data", disp_data, exp_disp.pop_front());
            end
            if (bus_ack) begin
                ack_cyc = cyc;
                if (exp_bus.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
                else chk("bus_rdata", bus_rdata, exp_bus.pop_front());
            end
        end
    end

    // Monitor for the zero-holdoff instance.
    always @(negedge vga_clk) begin
        if (!reset) begin
            if (disp_ready2) begin
                n_rdy2++;
                chk("disp_data2", disp_data2, 32'hDEADBEEF);
            end
            if (bus_ack2) begin
                n_ack2++;
                if (n_ack2 == 1) rdy_at_ack = n_rdy2;
                chk("bus_rdata2", bus_rdata2, 32'h5A5A0002);
            end
        end
    end

    task automatic bus_op(input logic wr, input logic [14:0] a, input logic [31:0] d,
                          input logic [31:0] exp);
        int n = 0;
        if (wr) exp_bus.push_back(hold_rd);
        else begin exp_bus.push_back(exp); hold_rd = exp; end
        bus_wr = wr; bus_rd = !wr; bus_addr = a; bus_wdata = d;
        do begin @(negedge vga_clk); n++; end while (!bus_ack && n < 30);
        if (!bus_ack) chk("bus_ack_timeout", 32'd0, 32'd1);
        @(posedge vga_clk); #1;
        bus_rd = 1'b0; bus_wr = 1'b0;
    endtask

    task automatic disp_op(input logic [14:0] a, input logic [31:0] exp);
        int n = 0;
        exp_disp.push_back(exp);
        disp_req = 1'b1; disp_addr = a;
        do begin @(negedge vga_clk); n++; end while (!disp_ready && n < 30);
        if (!disp_ready) chk("disp_ready_timeout", 32'd0, 32'd1);
        @(posedge vga_clk); #1;
        disp_req = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_disp_ready"}, disp_ready, 0);
        chk({tag, "_bus_ack"},    bus_ack, 0);
        chk({tag, "_mem_en"},     mem_en, 0);
        chk({tag, "_mem_we"},     mem_we, 0);
        chk({tag, "_mem_addr"},   mem_addr, 0);
        chk({tag, "_mem_wdata"},  mem_wdata, 0);
        chk({tag, "_disp_data"},  disp_data, 0);
        chk({tag, "_bus_rdata"},  bus_rdata, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hold_rd = '0;
        disp_req = 0; disp_addr = '0; bus_rd = 0; bus_wr = 0; bus_addr = '0; bus_wdata = '0;
        disp_req2 = 0; disp_addr2 = '0; bus_rd2 = 0; bus_addr2 = '0;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        chk_zero("reset");

        // Load memory through the bus.
        @(posedge vga_clk); #1; reset = 1'b0;
        bus_op(1'b1, 15'h0010, 32'hDEADBEEF, 0);
        bus_op(1'b1, 15'h0020, 32'hA5A50001, 0);
        bus_op(1'b1, 15'h0030, 32'h5A5A0002, 0);

        // Display read timing and holdoff from a fresh reset.
        @(posedge vga_clk); #1; reset = 1'b1;
        @(posedge vga_clk); #1; hold_rd = '0;
        @(posedge vga_clk); #1;
        reset = 1'b0; disp_req = 1'b1; disp_addr = 15'h0010;
        exp_disp.push_back(32'hDEADBEEF);
        @(negedge vga_clk); chk("c0_mem_en", mem_en, 0);
        @(negedge vga_clk); chk("c1_mem_en", mem_en, 1);
        chk("c1_mem_we", mem_we, 0); chk("c1_mem_addr", mem_addr, 32'h0010);
        @(negedge vga_clk); chk("c2_mem_en", mem_en, 0); chk("c2_disp_ready", disp_ready, 0);
        exp_disp.push_back(32'hDEADBEEF);
        @(negedge vga_clk); chk("c3_disp_ready", disp_ready, 1);
        @(negedge vga_clk); chk("c4_holdoff_mem_en", mem_en, 0);
        @(negedge vga_clk); chk("c5_holdoff_mem_en", mem_en, 0);
        @(negedge vga_clk); chk("c6_regrant_mem_en", mem_en, 1);
        @(negedge vga_clk);
        @(negedge vga_clk); chk("c8_disp_ready", disp_ready, 1);
        @(posedge vga_clk); #1; disp_req = 1'b0;
        repeat (3) @(posedge vga_clk); #1;

        // Bus write at top address, then read it back.
        exp_bus.push_back(hold_rd);
        bus_wr = 1'b1; bus_addr = 15'h7FFF; bus_wdata = 32'h12345678;
        @(negedge vga_clk);
        @(negedge vga_clk); chk("w_mem_en", mem_en, 1); chk("w_mem_we", mem_we, 1);
        chk("w_mem_addr", mem_addr, 32'h7FFF); chk("w_mem_wdata", mem_wdata, 32'h12345678);
        @(negedge vga_clk); chk("w_bus_ack", bus_ack, 1); chk("w_mem_en_off", mem_en, 0);
        @(posedge vga_clk); #1; bus_wr = 1'b0;
        @(negedge vga_clk); chk("w_no_regrant", mem_en, 0);
        @(posedge vga_clk); #1;
        bus_op(1'b0, 15'h7FFF, 0, 32'h12345678);
        chk("disp_data_hold", disp_data, 32'hDEADBEEF);
        chk("bus_rdata_hold", bus_rdata, 32'h12345678);
        repeat (3) @(posedge vga_clk); #1;

        // Simultaneous display and bus requests: display first.
        fork
            disp_op(15'h0020, 32'hA5A50001);
            bus_op(1'b0, 15'h0030, 0, 32'h5A5A0002);
        join
        chk("order_ack_after_ready", 32'(ack_cyc - rdy_cyc), 32'd3);
        repeat (3) @(posedge vga_clk); #1;

        // Reset in the cycle after mem_en of a bus read.
        bus_rd = 1'b1; bus_addr = 15'h0030;
        @(negedge vga_clk);
        @(negedge vga_clk); chk("abort_mem_en", mem_en, 1);
        @(posedge vga_clk); #1; reset = 1'b1;
        @(posedge vga_clk); #1;
        reset = 1'b0; bus_rd = 1'b0; hold_rd = '0;
        disp_req = 1'b1; disp_addr = 15'h0010;
        exp_disp.push_back(32'hDEADBEEF);
        @(negedge vga_clk); chk_zero("abort");
        @(negedge vga_clk); chk("post_reset_mem_en", mem_en, 1);
        chk("post_reset_mem_addr", mem_addr, 32'h0010);
        repeat (3) @(posedge vga_clk); #1; disp_req = 1'b0;
        repeat (4) @(posedge vga_clk); #1;

        // Starvation: display held continuously on the zero-holdoff instance.
        disp_req2 = 1'b1; disp_addr2 = 15'h0010; bus_rd2 = 1'b1; bus_addr2 = 15'h0030;
`ifdef VRAM_ARB_FAIRNESS_EN
        begin
            int n = 0;
            do begin @(negedge vga_clk); n++; end while (!bus_ack2 && n < 60);
            chk("fair_bus_ack", bus_ack2, 1);
            chk("fair_grants_before_bus", 32'(rdy_at_ack), 32'd4);
        end
        @(posedge vga_clk); #1; bus_rd2 = 1'b0; disp_req2 = 1'b0;
`else
        repeat (40) @(negedge vga_clk);
        chk("strict_no_bus_ack", 32'(n_ack2), 32'd0);
        chk("strict_disp_busy", 32'(n_rdy2 >= 10), 32'd1);
        @(posedge vga_clk); #1; disp_req2 = 1'b0;
        begin
            int n = 0;
            do begin @(negedge vga_clk); n++; end while (!bus_ack2 && n < 30);
            chk("strict_bus_after_drop", bus_ack2, 1);
        end
        @(posedge vga_clk); #1; bus_rd2 = 1'b0;
`endif
        repeat (10) @(negedge vga_clk);
        chk("disp_queue_empty", 32'(exp_disp.size()), 32'd0);
        chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        chk("nh_single_bus_ack", 32'(n_ack2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
